// File: rtl/alarm_event_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_event_gen_if
//  Description : Event/status bundle between the timekeeping side, the alarm
//                FSM and the alarm event generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alarm_event_gen_if;
    logic [2:0] state_i;
    logic       sec_tick_i;
    logic [4:0] cur_hh_i;
    logic [5:0] cur_mm_i;
    logic [5:0] cur_ss_i;
    logic [4:0] alarm_hh_i;
    logic [5:0] alarm_mm_i;
    logic       alarm_start_o;
    logic       alarm_timeout_o;
    logic       alarm_snooze_timeout_o;
    logic       alarm_auto_off_o;
    logic       ring_o;
    logic [3:0] snooze_cnt_o;

    // Event generator side
    modport master (
        input  state_i, sec_tick_i, cur_hh_i, cur_mm_i, cur_ss_i,
               alarm_hh_i, alarm_mm_i,
        output alarm_start_o, alarm_timeout_o, alarm_snooze_timeout_o,
               alarm_auto_off_o, ring_o, snooze_cnt_o
    );

    // FSM / timekeeping side
    modport slave (
        output state_i, sec_tick_i, cur_hh_i, cur_mm_i, cur_ss_i,
               alarm_hh_i, alarm_mm_i,
        input  alarm_start_o, alarm_timeout_o, alarm_snooze_timeout_o,
               alarm_auto_off_o, ring_o, snooze_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/alarm_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_event_gen
//  Description : Alarm event generator - start/timeout/snooze-timeout pulses,
//                ring enable and snooze count. Optional snooze limit enabled
//                by defining ALARM_SNOOZE_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_event_gen #(
    parameter int ALARM_LEN_S  = 60,
    parameter int SNOOZE_LEN_S = 300,
    parameter int MAX_SNOOZES  = 3
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    alarm_event_gen_if.master  bus
);
    localparam logic [2:0] c_st_idle   = 3'b000;
    localparam logic [2:0] c_st_set    = 3'b001;
    localparam logic [2:0] c_st_alarm  = 3'b010;
    localparam logic [2:0] c_st_snooze = 3'b011;

    localparam int c_max_len = (ALARM_LEN_S > SNOOZE_LEN_S) ? ALARM_LEN_S : SNOOZE_LEN_S;
    localparam int c_cnt_w   = $clog2(c_max_len + 1);

    localparam logic [c_cnt_w-1:0] c_ring_last = c_cnt_w'(ALARM_LEN_S - 1);
    localparam logic [c_cnt_w-1:0] c_snz_last  = c_cnt_w'(SNOOZE_LEN_S - 1);
    localparam logic [31:0]        c_max_snz   = MAX_SNOOZES;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam logic c_limit_en = 1'b1;
`else
    localparam logic c_limit_en = 1'b0;
`endif

    logic [2:0]         w_state;
    logic [2:0]         r_prev_state;
    logic               w_enter_alarm;
    logic               w_enter_snooze;
    logic               w_time_match;
    logic               w_ring_expire;
    logic               w_snz_expire;
    logic               w_limit_hit;

    logic [c_cnt_w-1:0] r_ring_cnt;
    logic               r_ring_done;
    logic [c_cnt_w-1:0] r_snz_cnt;
    logic               r_snz_done;

    logic               r_start;
    logic               r_timeout;
    logic               r_snz_timeout;
    logic               r_auto_off;
    logic               r_ring;
    logic [3:0]         r_snooze_cnt;

    // Unused state codes collapse to IDLE so they never count or pulse.
    always_comb begin
        w_state = bus.state_i;
        if (bus.state_i > c_st_snooze) begin
            w_state = c_st_idle;
        end
    end

    assign w_enter_alarm  = (w_state == c_st_alarm)  && (r_prev_state != c_st_alarm);
    assign w_enter_snooze = (w_state == c_st_snooze) && (r_prev_state != c_st_snooze);

    assign w_time_match = (bus.cur_hh_i == bus.alarm_hh_i) &&
                          (bus.cur_mm_i == bus.alarm_mm_i) &&
                          (bus.cur_ss_i == 6'd0);

    // A tick on the entry cycle is swallowed by the entry clear.
    assign w_ring_expire = (w_state == c_st_alarm) && !w_enter_alarm && bus.sec_tick_i &&
                           !r_ring_done && (r_ring_cnt == c_ring_last);
    assign w_snz_expire  = (w_state == c_st_snooze) && !w_enter_snooze && bus.sec_tick_i &&
                           !r_snz_done && (r_snz_cnt == c_snz_last);

    assign w_limit_hit = c_limit_en && ({28'd0, r_snooze_cnt} >= c_max_snz);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev_state <= c_st_idle;
        end else begin
            r_prev_state <= w_state;
        end
    end

    // Ringing window counter; stops once the window has expired.
    always_ff @(posedge clk_i) begin
        if (rst_i || (w_state != c_st_alarm) || w_enter_alarm) begin
            r_ring_cnt  <= '0;
            r_ring_done <= 1'b0;
        end else if (bus.sec_tick_i && !r_ring_done) begin
            r_ring_cnt <= r_ring_cnt + 1'b1;
            if (w_ring_expire) begin
                r_ring_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (w_state != c_st_snooze) || w_enter_snooze) begin
            r_snz_cnt  <= '0;
            r_snz_done <= 1'b0;
        end else if (bus.sec_tick_i && !r_snz_done) begin
            r_snz_cnt <= r_snz_cnt + 1'b1;
            if (w_snz_expire) begin
                r_snz_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snooze_cnt <= 4'd0;
        end else if ((w_state == c_st_idle) || (w_state == c_st_set)) begin
            r_snooze_cnt <= 4'd0;
        end else if (w_enter_snooze && (r_snooze_cnt != 4'd15)) begin
            r_snooze_cnt <= r_snooze_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start       <= 1'b0;
            r_timeout     <= 1'b0;
            r_snz_timeout <= 1'b0;
            r_auto_off    <= 1'b0;
            r_ring        <= 1'b0;
        end else begin
            r_start       <= (w_state == c_st_set) && bus.sec_tick_i && w_time_match;
            r_timeout     <= w_ring_expire;
            r_snz_timeout <= w_snz_expire && !w_limit_hit;
            r_auto_off    <= w_snz_expire && w_limit_hit;
            r_ring        <= (w_state == c_st_alarm);
        end
    end

    assign bus.alarm_start_o          = r_start;
    assign bus.alarm_timeout_o        = r_timeout;
    assign bus.alarm_snooze_timeout_o = r_snz_timeout;
    assign bus.alarm_auto_off_o       = r_auto_off;
    assign bus.ring_o                 = r_ring;
    assign bus.snooze_cnt_o           = r_snooze_cnt;

endmodule
`default_nettype wire
